// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit owning the HI/LO pair.
//
// One iteration per clock: mult/multu use a shift-add over a 2*XLEN
// accumulator, div/divu use restoring shift-subtract. Signed operations run
// on operand magnitudes; the sign is re-applied when the final iteration
// writes HI/LO. A divide by zero skips the iterations and reports
// div_by_zero with done, leaving HI/LO untouched.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start, op       launch request (sampled when not busy); op: 00 mult,
//                   01 multu, 10 div, 11 divu
//   first, second   rs/rt operands (multiplicand/dividend, multiplier/divisor)
//   abort           pipeline flush, cancels an operation in flight
//   hi_we, lo_we    mthi/mtlo enables, wdata is the write data
//   busy            high while iterating (pipeline stall)
//   done            one-cycle completion pulse
//   div_by_zero     qualifies done: divisor was zero
//   hi, lo          HI/LO registers (product high/low, or remainder/quotient)
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] first,
  input  logic [XLEN-1:0] second,
  input  logic            abort,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  // Operation context captured at launch.
  typedef struct packed {
    logic is_div;
    logic neg_q;   // product sign (mult) or quotient sign (div)
    logic neg_r;   // remainder sign: follows the dividend
  } req_t;

  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  state_t              state, state_next;
  req_t                req;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   acc;   // mult: {partial high, multiplier}; div: {rem, quotient}
  logic [XLEN-1:0]     opb;   // multiplicand or divisor magnitude

  // ---------------------------------------------------------------- launch
  logic            accept, dbz_start;
  logic            sgn_op, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;

  assign accept    = start && (state != S_CALC);
  assign dbz_start = accept && op[1] && (second == '0);
  assign sgn_op    = ~op[0];
  assign a_neg     = sgn_op & first[XLEN-1];
  assign b_neg     = sgn_op & second[XLEN-1];
  // Magnitude of the most negative value is itself as an unsigned number.
  assign mag_a     = a_neg ? -first  : first;
  assign mag_b     = b_neg ? -second : second;

  // ------------------------------------------------------------- iteration
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;
  logic              last;

  // Shift-add: conditionally add the multiplicand into the high half, then
  // shift the whole accumulator right, carry included.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide: bring the next dividend bit into the remainder; keep
  // the difference only if it did not go negative. The remainder is always
  // below the divisor, so the shifted value fits in XLEN+1 bits.
  assign div_shift = acc[2*XLEN-1:XLEN-1];
  assign div_ge    = div_shift >= {1'b0, opb};
  assign div_rem   = div_ge ? XLEN'(div_shift - {1'b0, opb}) : div_shift[XLEN-1:0];
  assign div_next  = {div_rem, acc[XLEN-2:0], div_ge};

  assign last = (state == S_CALC) && !abort && (cnt == CNT_LAST);

  // Sign fix-up applied on the final iteration.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign prod_fix = req.neg_q ? -mul_next : mul_next;
  assign quo_fix  = req.neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
  assign rem_fix  = req.neg_r ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (dbz_start)   state_next = S_DONE;
        else if (accept) state_next = S_CALC;
        else             state_next = S_IDLE;
      end
      S_CALC: begin
        // Flush outranks completion on the last iteration.
        if (abort)                 state_next = S_IDLE;
        else if (cnt == CNT_LAST)  state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

  // div_by_zero is only set by a launch that goes straight to DONE, so it is
  // low in every other cycle, including a normal DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_by_zero <= 1'b0;
    else     div_by_zero <= dbz_start;
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      opb <= '0;
      req <= '0;
    end else if (accept && !dbz_start) begin
      cnt        <= '0;
      req.is_div <= op[1];
      req.neg_q  <= a_neg ^ b_neg;
      req.neg_r  <= a_neg;
      if (op[1]) begin
        acc <= {{XLEN{1'b0}}, mag_a};
        opb <= mag_b;
      end else begin
        acc <= {{XLEN{1'b0}}, mag_b};
        opb <= mag_a;
      end
    end else if (state == S_CALC) begin
      acc <= req.is_div ? div_next : mul_next;
      if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
    end
  end

  // HI/LO: result on the final iteration; mthi/mtlo only outside CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (last) begin
      if (req.is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        hi <= prod_fix[2*XLEN-1:XLEN];
        lo <= prod_fix[XLEN-1:0];
      end
    end else if (state != S_CALC) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases from the test plan,
// then randomized operations checked against a plain-arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] first = '0;
  logic [31:0] second = '0;
  logic        abort = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .first(first),
    .second(second), .abort(abort), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = ua * ub;
      2'b10: begin
        q = sa / sb;
        r = sa % sb;
        p = {32'(r), 32'(q)};
      end
      default: p = {32'(ua % ub), 32'(ua / ub)};
    endcase
    return p;
  endfunction

  // Launch in the current cycle (cycle 0); end in the done cycle.
  // mt_cyc > 0 pulses hi_we during that CALC cycle, which must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int mt_cyc);
    logic [63:0] r;
    logic dz;
    dz = o[1] && (b == 32'h0);
    r  = dz ? {m_hi, m_lo} : model(o, a, b);
    op = o; first = a; second = b; start = 1'b1;
    tick();
    start = 1'b0;
    if (!dz) begin
      for (int c = 1; c <= 32; c++) begin
        chk("calc_busy_done", {62'h0, busy, done}, 64'h2);
        if (c == mt_cyc) begin
          hi_we = 1'b1; wdata = 32'hDEADBEEF;
          tick();
          hi_we = 1'b0;
          chk("mthi_in_calc_ignored", {32'h0, hi}, {32'h0, m_hi});
        end else begin
          tick();
        end
      end
    end
    chk("done_flags", {61'h0, busy, done, div_by_zero}, {61'h0, 1'b0, 1'b1, dz});
    chk("result_hi", {32'h0, hi}, {32'h0, r[63:32]});
    chk("result_lo", {32'h0, lo}, {32'h0, r[31:0]});
    m_hi = r[63:32];
    m_lo = r[31:0];
  endtask

  task automatic mt(input logic sel_hi, input logic [31:0] d);
    if (sel_hi) hi_we = 1'b1; else lo_we = 1'b1;
    wdata = d;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    if (sel_hi) m_hi = d; else m_lo = d;
    chk("mt_write", {hi, lo}, {m_hi, m_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic seen_done;
    logic [31:0] a, b;
    logic [1:0]  o;

    // Reset state
    #1;
    chk("reset_outputs", {29'h0, busy, done, div_by_zero, hi}, 64'h0);
    chk("reset_lo", {32'h0, lo}, 64'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Directed test-plan cases with literal expectations
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, 0);
    chk("mult_lit", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    tick();
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("multu_lit", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0);   // back-to-back from DONE
    chk("div_lit", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0);
    chk("divu_lit", {hi, lo}, 64'h00000001_7FFFFFFC);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("div_ovf_lit", {hi, lo}, 64'h00000000_80000000);
    tick();
    mt(1'b1, 32'h1234);
    run_op(2'b11, 32'd55, 32'd0, 0);
    chk("dbz_hi_kept", {32'h0, hi}, 64'h1234);
    tick();
    chk("dbz_clears", {61'h0, busy, done, div_by_zero}, 64'h0);

    // mthi during CALC ignored; mthi in DONE overwrites the result
    run_op(2'b01, 32'd1000, 32'd3000, 5);
    mt(1'b1, 32'hCAFE0001);
    mt(1'b0, 32'h0BADF00D);

    // Abort in cycle 10 of a mult
    op = 2'b00; first = 32'd123; second = 32'd456; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {62'h0, busy, done}, 64'h0);
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    chk("abort_no_done", {63'h0, seen_done}, 64'h0);
    chk("abort_hilo_kept", {hi, lo}, {m_hi, m_lo});

    // Start and abort together in IDLE: start wins
    op = 2'b11; first = 32'd100; second = 32'd7; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_beats_abort", {63'h0, busy}, 64'h1);
    for (int c = 1; c <= 32; c++) tick();
    chk("sba_result", {hi, lo}, model(2'b11, 32'd100, 32'd7));
    m_hi = hi === 32'd2 ? 32'd2 : 32'd2;  // 100 = 14*7 + 2
    m_lo = 32'd14;
    tick();

    // Reset in cycle 20 of a div
    op = 2'b10; first = 32'd999; second = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    #1;
    chk("midop_reset", {29'h0, busy, done, div_by_zero, hi}, 64'h0);
    chk("midop_reset_lo", {32'h0, lo}, 64'h0);
    m_hi = '0; m_lo = '0;
    tick();
    rst = 1'b0;
    tick();

    // Randomized operations, some back-to-back, some with idle gaps
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = ($urandom_range(0, 9) == 0) ? 32'h0 : pick();
      run_op(o, a, b, 0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
